// File: rtl/shift_exec_stage_pkg.sv
// Shared constants for the shift execute stage: data/register widths, MIPS shift
// funct codes, shifter operation encodings, and the funct legality helper.
package shift_exec_stage_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  localparam logic [1:0] SHIFTOP_SLL = 2'b00;
  localparam logic [1:0] SHIFTOP_SRL = 2'b10;
  localparam logic [1:0] SHIFTOP_SRA = 2'b11;

  function automatic logic funct_is_legal(input logic [5:0] funct);
    case (funct)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
      FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shifter.sv
// Combinational 32-bit barrel shifter: left, logical right, arithmetic right.
module shifter
  import shift_exec_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [4:0]            B,
  input  logic [1:0]            Shiftop,
  output logic [DATA_WIDTH-1:0] Result
);

  // Shiftop[1]==0 is a left shift, so the unlisted 2'b01 code also shifts left.
  always_comb begin
    Result = A;
    if (!Shiftop[1]) begin
      Result = A << B;
    end else if (Shiftop[0]) begin
      Result = $signed(A) >>> B;
    end else begin
      Result = A >> B;
    end
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined MIPS shift execute unit with valid/ready handshake and flush.
// Optional funct legality check and out_illegal port enabled by SHIFT_ILLEGAL_CHECK_EN.
module shift_exec_stage
  import shift_exec_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_funct,
  input  logic [4:0]            in_shamt,
  input  logic [DATA_WIDTH-1:0] in_rs,
  input  logic [DATA_WIDTH-1:0] in_rt,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wen
`ifdef SHIFT_ILLEGAL_CHECK_EN
  ,
  output logic                  out_illegal
`endif
);

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [4:0]            s1_b_q, s1_b_d;
  logic [1:0]            s1_op_q, s1_op_d;
  logic [REG_ADDR_W-1:0] s1_rd_q, s1_rd_d;
  logic                  s1_ill_q, s1_ill_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_result_q, s2_result_d;
  logic [REG_ADDR_W-1:0] s2_rd_q, s2_rd_d;
  logic                  s2_wen_q, s2_wen_d;
`ifdef SHIFT_ILLEGAL_CHECK_EN
  logic                  s2_ill_q, s2_ill_d;
`endif

  logic                  s2_free, s1_adv, in_xfer, dec_illegal;
  logic [DATA_WIDTH-1:0] shift_result;
  logic                  unused_bits;

  assign unused_bits = ^{in_rs[DATA_WIDTH-1:5], in_funct[5:3]};

`ifdef SHIFT_ILLEGAL_CHECK_EN
  assign dec_illegal = !funct_is_legal(in_funct);
`else
  assign dec_illegal = 1'b0;
`endif

  // Flush forces in_ready high but the accepted op is dropped (in_xfer gated).
  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = flush || !s1_valid_q || s1_adv;
  assign in_xfer  = in_valid && in_ready && !flush;

  shifter u_shifter (
    .A       (s1_a_q),
    .B       (s1_b_q),
    .Shiftop (s1_op_q),
    .Result  (shift_result)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s1_rd_d     = s1_rd_q;
    s1_ill_d    = s1_ill_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_rd_d     = s2_rd_q;
    s2_wen_d    = s2_wen_q;
`ifdef SHIFT_ILLEGAL_CHECK_EN
    s2_ill_d    = s2_ill_q;
`endif
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_xfer) begin
        s1_valid_d = 1'b1;
        s1_a_d     = in_rt;
        s1_b_d     = in_funct[2] ? in_rs[4:0] : in_shamt;
        s1_op_d    = in_funct[1:0];
        s1_rd_d    = in_rd;
        s1_ill_d   = dec_illegal;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
      if (s1_adv) begin
        s2_valid_d  = 1'b1;
        s2_result_d = s1_ill_q ? '0 : shift_result;
        s2_rd_d     = s1_rd_q;
        s2_wen_d    = (s1_rd_q != '0) && !s1_ill_q;
`ifdef SHIFT_ILLEGAL_CHECK_EN
        s2_ill_d    = s1_ill_q;
`endif
      end else if (out_ready) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s1_rd_q     <= '0;
      s1_ill_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_rd_q     <= '0;
      s2_wen_q    <= 1'b0;
`ifdef SHIFT_ILLEGAL_CHECK_EN
      s2_ill_q    <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_rd_q     <= s1_rd_d;
      s1_ill_q    <= s1_ill_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_rd_q     <= s2_rd_d;
      s2_wen_q    <= s2_wen_d;
`ifdef SHIFT_ILLEGAL_CHECK_EN
      s2_ill_q    <= s2_ill_d;
`endif
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_rd     = s2_rd_q;
  assign out_wen    = s2_wen_q;
`ifdef SHIFT_ILLEGAL_CHECK_EN
  assign out_illegal = s2_ill_q;
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage; expected values hand-computed.
// Covers SHIFT_ILLEGAL_CHECK_EN behaviour when that macro is defined.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_wen;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt, in_rd, out_rd;
  logic [31:0] in_rs, in_rt, out_result;
`ifdef SHIFT_ILLEGAL_CHECK_EN
  logic        out_illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_shamt   (in_shamt),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wen    (out_wen)
`ifdef SHIFT_ILLEGAL_CHECK_EN
    ,
    .out_illegal(out_illegal)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rd);
    in_valid = 1'b1;
    in_funct = f;
    in_shamt = sh;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct = '0; in_shamt = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_wen", {31'd0, out_wen}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SHIFT_ILLEGAL_CHECK_EN
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
`endif
    rst = 1'b0;

    // sll latency
    drive(6'h00, 5'd4, 32'h0, 32'h0000000F, 5'd8);
    chk("sll_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("sll_lat1_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("sll_valid", {31'd0, out_valid}, 32'd1);
    chk("sll_result", out_result, 32'h000000F0);
    chk("sll_rd", {27'd0, out_rd}, 32'd8);
    chk("sll_wen", {31'd0, out_wen}, 32'd1);
    step();
    chk("sll_drained", {31'd0, out_valid}, 32'd0);

    // sra then srl back-to-back
    drive(6'h03, 5'd8, 32'h0, 32'h80000000, 5'd3);
    step();
    drive(6'h02, 5'd8, 32'h0, 32'h80000000, 5'd4);
    step();
    in_valid = 1'b0;
    chk("sra_valid", {31'd0, out_valid}, 32'd1);
    chk("sra_result", out_result, 32'hFF800000);
    chk("sra_rd", {27'd0, out_rd}, 32'd3);
    step();
    chk("srl_valid", {31'd0, out_valid}, 32'd1);
    chk("srl_result", out_result, 32'h00800000);
    chk("srl_rd", {27'd0, out_rd}, 32'd4);
    step();
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // srav amount 3, sllv amount 0 (rs upper bits and shamt ignored)
    drive(6'h07, 5'd0, 32'h00000023, 32'hFFFFFFF0, 5'd5);
    step();
    drive(6'h04, 5'd31, 32'h00000020, 32'h12345678, 5'd6);
    step();
    in_valid = 1'b0;
    chk("srav_result", out_result, 32'hFFFFFFFE);
    step();
    chk("sllv0_result", out_result, 32'h12345678);
    chk("sllv0_rd", {27'd0, out_rd}, 32'd6);
    step();

    // Backpressure: 4 ops, results 1,2,4,8 to rd 10..13
    out_ready = 1'b0;
    drive(6'h00, 5'd0, 32'h0, 32'h1, 5'd10);
    step();
    drive(6'h00, 5'd1, 32'h0, 32'h1, 5'd11);
    chk("bp_ready_s1", {31'd0, in_ready}, 32'd1);
    step();
    drive(6'h00, 5'd2, 32'h0, 32'h1, 5'd12);
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_result", out_result, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_r0", out_result, 32'd1);
    chk("bp_rd0", {27'd0, out_rd}, 32'd10);
    step();
    drive(6'h00, 5'd3, 32'h0, 32'h1, 5'd13);
    chk("bp_r1", out_result, 32'd2);
    chk("bp_rd1", {27'd0, out_rd}, 32'd11);
    step();
    in_valid = 1'b0;
    chk("bp_r2", out_result, 32'd4);
    chk("bp_rd2", {27'd0, out_rd}, 32'd12);
    step();
    chk("bp_r3", out_result, 32'd8);
    chk("bp_rd3", {27'd0, out_rd}, 32'd13);
    chk("bp_v3", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush with both stages full and a pending input
    out_ready = 1'b0;
    drive(6'h00, 5'd1, 32'h0, 32'h11, 5'd20);
    step();
    drive(6'h00, 5'd1, 32'h0, 32'h22, 5'd20);
    step();
    drive(6'h00, 5'd1, 32'h0, 32'h33, 5'd20);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid0", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("flush_valid1", {31'd0, out_valid}, 32'd0);
    drive(6'h00, 5'd1, 32'h0, 32'h3, 5'd21);
    step();
    in_valid = 1'b0;
    chk("post_flush_lat", {31'd0, out_valid}, 32'd0);
    step();
    chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
    chk("post_flush_result", out_result, 32'd6);
    step();

    // rd=0 suppresses write enable
    drive(6'h00, 5'd2, 32'h0, 32'h1, 5'd0);
    step();
    in_valid = 1'b0;
    step();
    chk("rd0_result", out_result, 32'd4);
    chk("rd0_wen", {31'd0, out_wen}, 32'd0);
    step();

    // funct 0x01
    drive(6'h01, 5'd3, 32'h0, 32'h1, 5'd7);
    step();
    in_valid = 1'b0;
    step();
    chk("f01_valid", {31'd0, out_valid}, 32'd1);
`ifdef SHIFT_ILLEGAL_CHECK_EN
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_result", out_result, 32'd0);
    chk("ill_wen", {31'd0, out_wen}, 32'd0);
`else
    chk("f01_as_sll", out_result, 32'd8);
    chk("f01_wen", {31'd0, out_wen}, 32'd1);
`endif
    step();

    // rst mid-stream
    out_ready = 1'b0;
    drive(6'h00, 5'd1, 32'h0, 32'h5, 5'd9);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_result", out_result, 32'd0);
    chk("mrst_rd", {27'd0, out_rd}, 32'd0);
    chk("mrst_wen", {31'd0, out_wen}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("mrst_stays_empty", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
